// File: rtl/alu_fifo.sv
// Synchronous FIFO with registered status flags, one-cycle ack/err pulses and a
// three-state status FSM (EMPTY / NORMAL / FULL). Synchronous active-high reset.
module alu_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_NORMAL = 2'b01,
    ST_FULL   = 2'b10
  } state_t;

  state_t                st;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  // Acceptance uses the registered flags only, so push/pop never reach an output combinationally.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next = data_count;
    if (do_push && !do_pop)
      count_next = data_count + CNT_ONE;
    else if (do_pop && !do_push)
      count_next = data_count - CNT_ONE;
  end

  // NOTE: storage has no reset; contents are don't-care until written, and leaving them
  // unreset lets the array map onto plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push && !reset_n)
      mem[tail] <= wData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      st         <= ST_EMPTY;
      empty      <= 1'b1;
      full       <= 1'b0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      dout       <= '0;
    end else begin
      wr_ack <= do_push;
      wr_err <= push & full;
      rd_ack <= do_pop;
      rd_err <= pop & empty;

      if (do_push)
        tail <= tail + PTR_ONE;
      if (do_pop) begin
        head <= head + PTR_ONE;
        dout <= mem[head];
      end

      data_count <= count_next;
      empty      <= (count_next == CNT_ZERO);
      full       <= (count_next == CNT_DEPTH);

      case (st)
        ST_EMPTY:  if (do_push && !do_pop) st <= ST_NORMAL;
        ST_NORMAL: begin
          if (count_next == CNT_ZERO)
            st <= ST_EMPTY;
          else if (count_next == CNT_DEPTH)
            st <= ST_FULL;
        end
        ST_FULL:   if (do_pop && !do_push) st <= ST_NORMAL;
        default:   st <= ST_EMPTY;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_alu_fifo.sv
// Directed self-checking bench for alu_fifo: reset, error pulses, ordering, wrap,
// simultaneous push/pop at the boundaries, and reset while requests are pending.
module tb_alu_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        push;
  logic [31:0] wData;
  logic        pop;
  logic [31:0] dout;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
  logic [3:0]  data_count;
  logic [1:0]  state;

  int tests  = 0;
  int failed = 0;

  alu_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .wData      (wData),
    .pop        (pop),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Apply one request cycle, then look at outputs 1 ns after the edge.
  task automatic step(input logic p, input logic [31:0] d, input logic q);
    push  = p;
    wData = d;
    pop   = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    push = 1'b0; pop = 1'b0; wData = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    tests++; if (empty !== 1'b1) begin failed++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (data_count !== 4'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", data_count); end
    tests++; if (state !== 2'b00) begin failed++; $display("FAIL reset_state got %b exp 00", state); end
    tests++; if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin failed++; $display("FAIL reset_pulses got %b exp 0000", {wr_ack, wr_err, rd_ack, rd_err}); end
    tests++; if (dout !== 32'h0) begin failed++; $display("FAIL reset_dout got %h exp 0", dout); end
  endtask

  task automatic test_pop_empty();
    step(1'b0, 32'h0, 1'b1);
    tests++; if (rd_err !== 1'b1 || rd_ack !== 1'b0) begin failed++; $display("FAIL pop_empty_err got err=%b ack=%b exp err=1 ack=0", rd_err, rd_ack); end
    tests++; if (dout !== 32'h0 || empty !== 1'b1 || data_count !== 4'd0) begin failed++; $display("FAIL pop_empty_status got dout=%h empty=%b cnt=%0d exp 0/1/0", dout, empty, data_count); end
    step(1'b0, 32'h0, 1'b0);
    tests++; if (rd_err !== 1'b0) begin failed++; $display("FAIL rd_err_one_cycle got %b exp 0", rd_err); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h1111_1111, 1'b0);
    tests++; if (wr_ack !== 1'b1 || data_count !== 4'd1 || state !== 2'b01 || empty !== 1'b0) begin failed++; $display("FAIL b2b_push1 got ack=%b cnt=%0d st=%b empty=%b exp 1/1/01/0", wr_ack, data_count, state, empty); end
    step(1'b1, 32'h2222_2222, 1'b0);
    tests++; if (wr_ack !== 1'b1 || data_count !== 4'd2) begin failed++; $display("FAIL b2b_push2 got ack=%b cnt=%0d exp 1/2", wr_ack, data_count); end
    step(1'b0, 32'h0, 1'b1);
    tests++; if (rd_ack !== 1'b1 || dout !== 32'h1111_1111 || wr_ack !== 1'b0) begin failed++; $display("FAIL b2b_pop1 got ack=%b dout=%h wr_ack=%b exp 1/11111111/0", rd_ack, dout, wr_ack); end
    step(1'b0, 32'h0, 1'b1);
    tests++; if (rd_ack !== 1'b1 || dout !== 32'h2222_2222) begin failed++; $display("FAIL b2b_pop2 got ack=%b dout=%h exp 1/22222222", rd_ack, dout); end
    tests++; if (empty !== 1'b1 || data_count !== 4'd0 || state !== 2'b00) begin failed++; $display("FAIL b2b_drained got empty=%b cnt=%0d st=%b exp 1/0/00", empty, data_count, state); end
    step(1'b0, 32'h0, 1'b0);
    tests++; if (rd_ack !== 1'b0 || dout !== 32'h2222_2222) begin failed++; $display("FAIL b2b_hold got ack=%b dout=%h exp 0/22222222", rd_ack, dout); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hA0 + i, 1'b0);
      tests++; if (wr_ack !== 1'b1 || data_count !== 4'(i + 1)) begin failed++; $display("FAIL fill_%0d got ack=%b cnt=%0d exp 1/%0d", i, wr_ack, data_count, i + 1); end
    end
    tests++; if (full !== 1'b1 || state !== 2'b10 || data_count !== 4'd8) begin failed++; $display("FAIL full_status got full=%b st=%b cnt=%0d exp 1/10/8", full, state, data_count); end
    step(1'b1, 32'hFF, 1'b0);
    tests++; if (wr_err !== 1'b1 || wr_ack !== 1'b0 || data_count !== 4'd8) begin failed++; $display("FAIL overflow got err=%b ack=%b cnt=%0d exp 1/0/8", wr_err, wr_ack, data_count); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1);
      tests++; if (rd_ack !== 1'b1 || dout !== 32'hA0 + i) begin failed++; $display("FAIL drain_%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, 32'hA0 + i); end
    end
    tests++; if (empty !== 1'b1 || state !== 2'b00) begin failed++; $display("FAIL full_drained got empty=%b st=%b exp 1/00", empty, state); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hB0 + i, 1'b0);
      tests++; if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin failed++; $display("FAIL wrap_prime_%0d got ack=%b err=%b exp 1/0", i, wr_ack, wr_err); end
    end
    for (int i = 3; i < 12; i++) begin
      step(1'b1, 32'hB0 + i, 1'b1);
      tests++; if (dout !== 32'hB0 + i - 3 || rd_ack !== 1'b1 || wr_ack !== 1'b1) begin failed++; $display("FAIL wrap_%0d got dout=%h rd=%b wr=%b exp %h/1/1", i, dout, rd_ack, wr_ack, 32'hB0 + i - 3); end
      tests++; if (wr_err !== 1'b0 || rd_err !== 1'b0 || data_count !== 4'd3) begin failed++; $display("FAIL wrap_err_%0d got werr=%b rerr=%b cnt=%0d exp 0/0/3", i, wr_err, rd_err, data_count); end
    end
    for (int i = 9; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1);
      tests++; if (dout !== 32'hB0 + i || rd_ack !== 1'b1) begin failed++; $display("FAIL wrap_tail_%0d got dout=%h ack=%b exp %h/1", i, dout, rd_ack, 32'hB0 + i); end
    end
    tests++; if (empty !== 1'b1 || data_count !== 4'd0) begin failed++; $display("FAIL wrap_drained got empty=%b cnt=%0d exp 1/0", empty, data_count); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) step(1'b1, 32'hC0 + i, 1'b0);
    step(1'b1, 32'hEE, 1'b1);
    tests++; if (wr_err !== 1'b1 || wr_ack !== 1'b0 || rd_ack !== 1'b1 || dout !== 32'hC0) begin failed++; $display("FAIL sim_full got werr=%b wack=%b rack=%b dout=%h exp 1/0/1/c0", wr_err, wr_ack, rd_ack, dout); end
    tests++; if (data_count !== 4'd7 || state !== 2'b01 || full !== 1'b0) begin failed++; $display("FAIL sim_full_status got cnt=%0d st=%b full=%b exp 7/01/0", data_count, state, full); end
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1);
      tests++; if (dout !== 32'hC0 + i) begin failed++; $display("FAIL sim_drain_%0d got %h exp %h", i, dout, 32'hC0 + i); end
    end
    step(1'b1, 32'hD5, 1'b1);
    tests++; if (rd_err !== 1'b1 || rd_ack !== 1'b0 || wr_ack !== 1'b1 || wr_err !== 1'b0) begin failed++; $display("FAIL sim_empty got rerr=%b rack=%b wack=%b werr=%b exp 1/0/1/0", rd_err, rd_ack, wr_ack, wr_err); end
    tests++; if (data_count !== 4'd1 || state !== 2'b01 || dout !== 32'hC7) begin failed++; $display("FAIL sim_empty_status got cnt=%0d st=%b dout=%h exp 1/01/c7", data_count, state, dout); end
    step(1'b0, 32'h0, 1'b1);
    tests++; if (dout !== 32'hD5 || rd_ack !== 1'b1 || empty !== 1'b1) begin failed++; $display("FAIL sim_empty_pop got dout=%h ack=%b empty=%b exp d5/1/1", dout, rd_ack, empty); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hE0 + i, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 32'hEF, 1'b0);
    reset_n = 1'b0;
    tests++; if (empty !== 1'b1 || data_count !== 4'd0 || wr_ack !== 1'b0 || wr_err !== 1'b0) begin failed++; $display("FAIL midreset got empty=%b cnt=%0d wack=%b werr=%b exp 1/0/0/0", empty, data_count, wr_ack, wr_err); end
    tests++; if (state !== 2'b00 || dout !== 32'h0) begin failed++; $display("FAIL midreset_state got st=%b dout=%h exp 00/0", state, dout); end
    step(1'b0, 32'h0, 1'b1);
    tests++; if (rd_err !== 1'b1 || rd_ack !== 1'b0 || dout !== 32'h0) begin failed++; $display("FAIL midreset_pop got err=%b ack=%b dout=%h exp 1/0/0", rd_err, rd_ack, dout); end
  endtask

  initial begin
    test_reset();
    test_pop_empty();
    test_back_to_back();
    test_full();
    test_wrap();
    test_simultaneous();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_fifo.md
ALU_FIFO -- requirements
Module: ALU_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of every stored word.
REQ-002 Parameter ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8 by default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-high (reset_n = 1 resets on the next rising clk edge).
REQ-005 push  input  1  write request; one request per cycle high.
REQ-006 wData  input  DATA_WIDTH  write data, sampled in the same cycle as push.
REQ-007 pop  input  1  read request; one request per cycle high.
REQ-008 dout  output  DATA_WIDTH  read data; valid while rd_ack = 1, held otherwise.
REQ-009 full  output  1  count == depth.
REQ-010 empty  output  1  count == 0.
REQ-011 wr_ack  output  1  one-cycle pulse: previous-cycle push accepted.
REQ-012 wr_err  output  1  one-cycle pulse: previous-cycle push rejected (full).
REQ-013 rd_ack  output  1  one-cycle pulse: previous-cycle pop served; dout valid.
REQ-014 rd_err  output  1  one-cycle pulse: previous-cycle pop rejected (empty).
REQ-015 data_count  output  ADDR_WIDTH+1  number of stored words, 0..depth.
REQ-016 state  output  2  status FSM state: EMPTY=2'b00, NORMAL=2'b01, FULL=2'b10; 2'b11 unused.

Function
REQ-017 Storage: DATA_WIDTH x depth register array, head (read) and tail (write) pointers of ADDR_WIDTH bits, both wrapping from depth-1 to 0 by natural overflow.
REQ-018 All decisions in a cycle use the pre-edge values of count/full/empty; no combinational path from push/pop to any output.
REQ-019 push=1, full=0: mem[tail] <= wData, tail+1, wr_ack=1 next cycle, wr_err=0.
REQ-020 push=1, full=1: no write, tail and count unchanged, wr_err=1 next cycle, wr_ack=0.
REQ-021 pop=1, empty=0: dout <= mem[head], head+1, rd_ack=1 next cycle, rd_err=0.
REQ-022 pop=1, empty=1: head unchanged, dout unchanged, rd_err=1 next cycle, rd_ack=0.
REQ-023 push=0 / pop=0: corresponding ack and err are 0 next cycle (pulses last exactly one cycle per request).
REQ-024 Simultaneous push and pop, NORMAL: both succeed, count unchanged, wr_ack=rd_ack=1.
REQ-025 Simultaneous push and pop, EMPTY: pop errors (rd_err), push succeeds (wr_ack); count becomes 1; popped data not bypassed.
REQ-026 Simultaneous push and pop, FULL: push errors (wr_err), pop succeeds (rd_ack); count becomes depth-1.
REQ-027 Count: +1 on accepted push only, -1 on accepted pop only, unchanged otherwise; never exceeds depth or goes below 0.
REQ-028 FSM EMPTY -> NORMAL on accepted push without accepted pop; NORMAL -> EMPTY when count goes 1->0; NORMAL -> FULL when count goes depth-1->depth; FULL -> NORMAL on accepted pop without accepted push; all other cases hold.
REQ-029 full, empty, data_count, state updated on the same edge as the pointers; consistent every cycle (empty=1 iff state=EMPTY, full=1 iff state=FULL).
REQ-030 Latency: ack/err and dout appear one cycle after the request cycle; a requester may re-issue in the ack cycle (back-to-back at one word per cycle).

Reset
REQ-031 On reset_n=1 at a rising edge: head=tail=0, data_count=0, state=EMPTY, empty=1, full=0, wr_ack=wr_err=rd_ack=rd_err=0, dout=0.
REQ-032 Memory contents are not cleared; reset has priority over push/pop in the same cycle, and any request in flight is dropped with no ack or err.

Verification
REQ-033 Reset, then pop -> next cycle rd_err=1, rd_ack=0, dout=0, empty=1, data_count=0.
REQ-034 Push 0x11111111, 0x22222222 back-to-back, then two pops -> two wr_ack pulses, data_count 1 then 2, rd_ack with dout 0x11111111 then 0x22222222, empty=1 after.
REQ-035 Push 8 words 0xA0..0xA7 -> full=1, state=FULL, data_count=8; 9th push 0xFF -> wr_err=1, count stays 8; 8 pops return 0xA0..0xA7 in order.
REQ-036 Wrap: push/pop 12 words interleaved (count 0..3) -> order preserved across pointer wrap 7->0, no err pulses.
REQ-037 With FIFO full, push+pop same cycle -> wr_err=1, rd_ack=1, data_count=7, state=NORMAL; with FIFO empty, push+pop -> rd_err=1, wr_ack=1, data_count=1.
REQ-038 Three words stored, reset_n=1 for one cycle with push=1 -> empty=1, data_count=0, no wr_ack; next pop -> rd_err=1.
